// File: rtl/stream_mux_arbiter.sv
// rtl/stream_mux_arbiter.sv - registered N-to-1 valid/ready stream mux with direct-select and round-robin modes
module stream_mux_arbiter #(
   parameter int NrOfBits     = 8,
   parameter int NrOfChannels = 8,
   parameter int SelBits      = 3
) (
   input  logic                             Clock,
   input  logic                             Reset_n,
   input  logic                             Enable,
   input  logic                             Mode,
   input  logic [SelBits-1:0]               Sel,
   input  logic [NrOfChannels*NrOfBits-1:0] MuxIn,
   input  logic [NrOfChannels-1:0]          InValid,
   output logic [NrOfChannels-1:0]          InReady,
   output logic [NrOfBits-1:0]              MuxOut,
   output logic                             OutValid,
   input  logic                             OutReady,
   output logic [SelBits-1:0]               OutChannel
);

   // Output register and arbitration pointer (last served channel).
   logic [NrOfBits-1:0] mux_out_q, mux_out_d;
   logic                out_valid_q, out_valid_d;
   logic [SelBits-1:0]  out_channel_q, out_channel_d;
   logic [SelBits-1:0]  ptr_q, ptr_d;

   // Arbitration results.
   logic                load;
   logic                sel_found;
   logic [SelBits-1:0]  sel_idx;
   logic                hi_found;
   logic [SelBits-1:0]  hi_idx;
   logic                lo_found;
   logic [SelBits-1:0]  lo_idx;
   logic                cand_found;
   logic [SelBits-1:0]  cand_idx;
   logic [NrOfBits-1:0] cand_data;
   logic                grant;

   // The output slot can take a word when enabled and it is empty or being consumed.
   assign load = Enable & (~out_valid_q | OutReady);

   // Direct select: Sel must name an existing, valid channel; out-of-range values never match.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int c = 0; c < NrOfChannels; c++) begin
         if ((Sel == SelBits'(c)) && InValid[c]) begin
            sel_found = 1'b1;
            sel_idx   = SelBits'(c);
         end
      end
   end

   // Round-robin: lowest valid channel above ptr, otherwise lowest valid channel overall
   // (which is then at or below ptr). Equivalent to scanning ptr+1 .. ptr modulo NrOfChannels.
   always_comb begin
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_found = 1'b0;
      lo_idx   = '0;
      for (int c = NrOfChannels - 1; c >= 0; c--) begin
         if (InValid[c]) begin
            lo_found = 1'b1;
            lo_idx   = SelBits'(c);
            if (c > int'(ptr_q)) begin
               hi_found = 1'b1;
               hi_idx   = SelBits'(c);
            end
         end
      end
   end

   // Pick the candidate for the active mode and fetch its data word.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = '0;
      if (!Mode) begin
         cand_found = sel_found;
         cand_idx   = sel_idx;
      end else if (hi_found) begin
         cand_found = 1'b1;
         cand_idx   = hi_idx;
      end else begin
         cand_found = lo_found;
         cand_idx   = lo_idx;
      end
      cand_data = '0;
      for (int c = 0; c < NrOfChannels; c++) begin
         if (cand_idx == SelBits'(c)) begin
            cand_data = MuxIn[c*NrOfBits +: NrOfBits];
         end
      end
   end

   assign grant = load & cand_found;

   // One-hot ready toward the granted channel only; all-zero when nothing is granted.
   always_comb begin
      InReady = '0;
      for (int c = 0; c < NrOfChannels; c++) begin
         InReady[c] = grant & (cand_idx == SelBits'(c));
      end
   end

   // Next state: load on grant, empty on an idle load, drain while disabled, otherwise hold.
   always_comb begin
      mux_out_d     = mux_out_q;
      out_valid_d   = out_valid_q;
      out_channel_d = out_channel_q;
      ptr_d         = ptr_q;
      if (grant) begin
         mux_out_d     = cand_data;
         out_valid_d   = 1'b1;
         out_channel_d = cand_idx;
         ptr_d         = cand_idx;
      end else if (load) begin
         out_valid_d = 1'b0;
      end else if (out_valid_q && OutReady && !Enable) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; pointer resets to the last channel so channel 0 wins first.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         mux_out_q     <= '0;
         out_valid_q   <= 1'b0;
         out_channel_q <= '0;
         ptr_q         <= SelBits'(NrOfChannels - 1);
      end else begin
         mux_out_q     <= mux_out_d;
         out_valid_q   <= out_valid_d;
         out_channel_q <= out_channel_d;
         ptr_q         <= ptr_d;
      end
   end

   assign MuxOut     = mux_out_q;
   assign OutValid   = out_valid_q;
   assign OutChannel = out_channel_q;

endmodule

// File: tb/tb_stream_mux_arbiter.sv
// tb/tb_stream_mux_arbiter.sv - scoreboard bench for stream_mux_arbiter (8-channel and 5-channel instances)
module tb_stream_mux_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;

   // 8-channel instance
   logic        mode;
   logic [2:0]  sel;
   logic [63:0] mux_in;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic [7:0]  mux_out;
   logic        out_valid;
   logic        out_ready;
   logic [2:0]  out_ch;

   // 5-channel instance
   logic        mode_b;
   logic [2:0]  sel_b;
   logic [39:0] mux_in_b;
   logic [4:0]  in_valid_b;
   logic [4:0]  in_ready_b;
   logic [7:0]  mux_out_b;
   logic        out_valid_b;
   logic        out_ready_b;
   logic [2:0]  out_ch_b;

   int          checks = 0;
   int          errors = 0;
   logic [10:0] exp_q[$];
   logic [10:0] exp_e;

   always #5 clk = ~clk;

   stream_mux_arbiter #(.NrOfBits(8), .NrOfChannels(8), .SelBits(3)) dut_a (
      .Clock(clk), .Reset_n(rst_n), .Enable(en), .Mode(mode), .Sel(sel),
      .MuxIn(mux_in), .InValid(in_valid), .InReady(in_ready), .MuxOut(mux_out),
      .OutValid(out_valid), .OutReady(out_ready), .OutChannel(out_ch)
   );

   stream_mux_arbiter #(.NrOfBits(8), .NrOfChannels(5), .SelBits(3)) dut_b (
      .Clock(clk), .Reset_n(rst_n), .Enable(en), .Mode(mode_b), .Sel(sel_b),
      .MuxIn(mux_in_b), .InValid(in_valid_b), .InReady(in_ready_b), .MuxOut(mux_out_b),
      .OutValid(out_valid_b), .OutReady(out_ready_b), .OutChannel(out_ch_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [2:0] ch, input logic [7:0] d);
      exp_q.push_back({ch, d});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // channel c carries base + 4*c
   function automatic logic [63:0] pattern(input logic [7:0] base);
      logic [63:0] r;
      for (int c = 0; c < 8; c++) r[c*8 +: 8] = base + 8'(4 * c);
      return r;
   endfunction

   // Monitor: every word the downstream consumes must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got ch %0d data 0x%0h expected no word at %0t", out_ch, mux_out, $time);
         end else begin
            exp_e = exp_q.pop_front();
            check("sb_data", 64'(mux_out), 64'(exp_e[7:0]));
            check("sb_ch", 64'(out_ch), 64'(exp_e[10:8]));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = '0; mux_in = '0; in_valid = '0; out_ready = 1'b1;
      mode_b = 1'b0; sel_b = '0; mux_in_b = '0; in_valid_b = '0; out_ready_b = 1'b1;
      #2;
      check("rst_mux_out", 64'(mux_out), 64'h0);
      check("rst_out_valid", 64'(out_valid), 64'h0);
      check("rst_out_ch", 64'(out_ch), 64'h0);
      check("rst_b_valid", 64'(out_valid_b), 64'h0);
      tick;
      rst_n = 1'b1;

      // T1: direct select of channel 2
      mode = 1'b0; sel = 3'd2; mux_in = pattern(8'h00); mux_in[23:16] = 8'hA5; in_valid = 8'h04;
      #1 check("t1_in_ready", 64'(in_ready), 64'h04);
      push(3'd2, 8'hA5);
      tick; in_valid = '0;
      #1;
      check("t1_mux_out", 64'(mux_out), 64'hA5);
      check("t1_out_valid", 64'(out_valid), 64'h1);
      check("t1_out_ch", 64'(out_ch), 64'h2);
      tick;
      check("t1_drain", 64'(out_valid), 64'h0);

      // T2: round-robin from reset, all channels valid
      rst_n = 1'b0; #1; rst_n = 1'b1;
      mode = 1'b1; in_valid = 8'hFF; mux_in = pattern(8'h10);
      for (int i = 0; i < 10; i++) begin
         push(3'(i % 8), 8'h10 + 8'(4 * (i % 8)));
         tick;
         check("t2_out_valid", 64'(out_valid), 64'h1);
         check("t2_out_ch", 64'(out_ch), 64'(i % 8));
      end
      in_valid = '0;
      tick;
      check("t2_idle", 64'(out_valid), 64'h0);

      // T3: backpressure holds 0x3C, then consume and refill in one cycle
      mode = 1'b0; sel = 3'd3; mux_in = pattern(8'h30); in_valid = 8'h08; out_ready = 1'b0;
      #1 check("t3_load_ready", 64'(in_ready), 64'h08);
      push(3'd3, 8'h3C);
      tick; mode = 1'b1; in_valid = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("t3_stall_ready", 64'(in_ready), 64'h00);
         check("t3_stall_data", 64'(mux_out), 64'h3C);
         check("t3_stall_ch", 64'(out_ch), 64'h3);
         tick;
      end
      out_ready = 1'b1;
      #1 check("t3_resume_ready", 64'(in_ready), 64'h10);
      push(3'd4, 8'h40);
      tick; in_valid = '0;
      #1;
      check("t3_refill_data", 64'(mux_out), 64'h40);
      check("t3_refill_valid", 64'(out_valid), 64'h1);
      tick;

      // T4: drain while disabled, then resume
      mode = 1'b1; in_valid = 8'h01; mux_in = pattern(8'h50);
      #1 check("t4_ready", 64'(in_ready), 64'h01);
      push(3'd0, 8'h50);
      tick; en = 1'b0;
      #1;
      check("t4_dis_ready", 64'(in_ready), 64'h00);
      check("t4_valid_held", 64'(out_valid), 64'h1);
      tick;
      check("t4_drained", 64'(out_valid), 64'h0);
      check("t4_dis_ready2", 64'(in_ready), 64'h00);
      tick;
      check("t4_still_empty", 64'(out_valid), 64'h0);
      en = 1'b1;
      #1 check("t4_resume_ready", 64'(in_ready), 64'h01);
      push(3'd0, 8'h50);
      tick; in_valid = '0;
      tick;
      check("t4_end_empty", 64'(out_valid), 64'h0);

      // T5: five channels, out-of-range select, then wrap modulo 5
      mode_b = 1'b0; sel_b = 3'd6; in_valid_b = 5'h1F;
      for (int c = 0; c < 5; c++) mux_in_b[c*8 +: 8] = 8'h60 + 8'(4 * c);
      #1 check("t5_sel6_ready", 64'(in_ready_b), 64'h00);
      tick;
      check("t5_sel6_valid", 64'(out_valid_b), 64'h0);
      sel_b = 3'd5;
      #1 check("t5_sel5_ready", 64'(in_ready_b), 64'h00);
      tick;
      check("t5_sel5_valid", 64'(out_valid_b), 64'h0);
      sel_b = 3'd4;
      #1 check("t5_sel4_ready", 64'(in_ready_b), 64'h10);
      tick;
      check("t5_sel4_data", 64'(mux_out_b), 64'h70);
      check("t5_sel4_ch", 64'(out_ch_b), 64'h4);
      mode_b = 1'b1;
      #1 check("t5_wrap_ready", 64'(in_ready_b), 64'h01);
      tick;
      check("t5_wrap_ch", 64'(out_ch_b), 64'h0);
      check("t5_wrap_data", 64'(mux_out_b), 64'h60);
      in_valid_b = '0;
      tick;

      // T6: asynchronous reset while a word is held
      mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b0; mux_in = pattern(8'h80);
      tick;
      check("t6_loaded_valid", 64'(out_valid), 64'h1);
      check("t6_loaded_data", 64'(mux_out), 64'h84);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_data", 64'(mux_out), 64'h0);
      check("t6_rst_valid", 64'(out_valid), 64'h0);
      check("t6_rst_ch", 64'(out_ch), 64'h0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      out_ready = 1'b1;
      #1 check("t6_first_ready", 64'(in_ready), 64'h01);
      push(3'd0, 8'h80);
      tick; in_valid = '0;
      tick;
      tick;

      check("sb_empty", 64'(exp_q.size()), 64'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
